// File: rtl/ex_stage_pipe_if.sv
// ID->EX->MEM bundle for ex_stage_pipe: ID operands/controls in, EX/MEM latch contents out.
// The slave modport is the execute stage; the master modport is whatever drives ID and consumes MEM.
interface ex_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int TAG_W = 4
);
  logic             id_valid;
  logic             ex_ready;
  logic             flush;
  logic             mem_ready;
  logic [XLEN-1:0]  id_inA;
  logic [XLEN-1:0]  id_inB;
  logic [XLEN-1:0]  id_imm;
  logic [XLEN-1:0]  id_pc4;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [XLEN-1:0]  mem_fwd;
  logic [XLEN-1:0]  wb_fwd;
  logic [3:0]       id_aluc;
  logic             id_aluimm;
  logic             id_shift;
  logic             id_regrt;
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_wmem;
  logic             id_branch;
  logic [RA_W-1:0]  id_rt;
  logic [RA_W-1:0]  id_rd;
  logic [TAG_W-1:0] ID_ins_type;
  logic [TAG_W-1:0] ID_ins_number;
  logic             ex_valid;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic             ex_wmem;
  logic             ex_branch;
  logic [XLEN-1:0]  ex_aluR;
  logic [XLEN-1:0]  ex_inB;
  logic [XLEN-1:0]  ex_pc;
  logic [RA_W-1:0]  ex_destR;
  logic [TAG_W-1:0] EXE_ins_type;
  logic [TAG_W-1:0] EXE_ins_number;

  modport master (
    output id_valid, flush, mem_ready, id_inA, id_inB, id_imm, id_pc4,
           fwd_a_sel, fwd_b_sel, mem_fwd, wb_fwd, id_aluc, id_aluimm, id_shift,
           id_regrt, id_wreg, id_m2reg, id_wmem, id_branch, id_rt, id_rd,
           ID_ins_type, ID_ins_number,
    input  ex_ready, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_aluR,
           ex_inB, ex_pc, ex_destR, EXE_ins_type, EXE_ins_number
  );

  modport slave (
    input  id_valid, flush, mem_ready, id_inA, id_inB, id_imm, id_pc4,
           fwd_a_sel, fwd_b_sel, mem_fwd, wb_fwd, id_aluc, id_aluimm, id_shift,
           id_regrt, id_wreg, id_m2reg, id_wmem, id_branch, id_rt, id_rd,
           ID_ins_type, ID_ins_number,
    output ex_ready, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_aluR,
           ex_inB, ex_pc, ex_destR, EXE_ins_type, EXE_ins_number
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage with valid/ready flow control, operand forwarding, flush and branch resolution.
// Define EX_MUL_EN to build the iterative shift-add multiplier for aluc=F (otherwise aluc=F yields 0).
module ex_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  ex_stage_pipe_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] aluc,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SH_W-1:0]        sh;
    sa = a;
    sb = b;
    sh = a[SH_W-1:0];
    case (aluc)
      4'h0:    alu_op = a + b;
      4'h1:    alu_op = a - b;
      4'h2:    alu_op = a & b;
      4'h3:    alu_op = a | b;
      4'h4:    alu_op = a ^ b;
      4'h5:    alu_op = ~(a | b);
      4'h6:    alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      4'h7:    alu_op = b << sh;
      4'h8:    alu_op = b >> sh;
      4'h9:    alu_op = sb >>> sh;
      default: alu_op = '0;
    endcase
  endfunction

  logic             vld_p0;
  logic [XLEN-1:0]  fa_p0, fb_p0, op_a_p0, op_b_p0, alu_r_p0, tgt_p0;
  logic [RA_W-1:0]  dest_p0;
  logic             adv;
  logic             load;
  logic             ld_vld, ld_wreg, ld_m2reg, ld_wmem, ld_br_en;
  logic [XLEN-1:0]  ld_alu, ld_inb, ld_pc;
  logic [RA_W-1:0]  ld_dest;
  logic [TAG_W-1:0] ld_type, ld_num;

`ifdef EX_MUL_EN
  localparam logic [3:0]      OP_MUL   = 4'hF;
  localparam logic [SH_W-1:0] LAST_STEP = SH_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t           state;
  logic [SH_W-1:0]  cnt;
  logic             mul_start;
  logic [XLEN-1:0]  mcand, mplier, prod;
  logic             sh_wreg, sh_m2reg, sh_wmem, sh_branch;
  logic [XLEN-1:0]  sh_inb, sh_pc;
  logic [RA_W-1:0]  sh_dest;
  logic [TAG_W-1:0] sh_type, sh_num;
`endif

  // ---- p0: operand select, ALU, branch target (combinational from ID) ----
  assign vld_p0 = bus.id_valid;
  assign adv    = ~bus.ex_valid | bus.mem_ready;

  always_comb begin
    case (bus.fwd_a_sel)
      2'b01:   fa_p0 = bus.mem_fwd;
      2'b10:   fa_p0 = bus.wb_fwd;
      default: fa_p0 = bus.id_inA;
    endcase
    case (bus.fwd_b_sel)
      2'b01:   fb_p0 = bus.mem_fwd;
      2'b10:   fb_p0 = bus.wb_fwd;
      default: fb_p0 = bus.id_inB;
    endcase
    op_a_p0  = bus.id_shift ? {{(XLEN-5){1'b0}}, bus.id_imm[10:6]} : fa_p0;
    op_b_p0  = bus.id_aluimm ? bus.id_imm : fb_p0;
    alu_r_p0 = alu_op(bus.id_aluc, op_a_p0, op_b_p0);
    tgt_p0   = bus.id_pc4 + {bus.id_imm[XLEN-3:0], 2'b00};
    dest_p0  = bus.id_regrt ? bus.id_rt : bus.id_rd;
  end

  // Latch source: live ID fields normally, shadow copy when a multiply completes.
  always_comb begin
    load     = adv;
    ld_vld   = vld_p0;
    ld_alu   = alu_r_p0;
    ld_inb   = fb_p0;
    ld_pc    = tgt_p0;
    ld_dest  = dest_p0;
    ld_wreg  = bus.id_wreg;
    ld_m2reg = bus.id_m2reg;
    ld_wmem  = bus.id_wmem;
    ld_br_en = bus.id_branch;
    ld_type  = bus.ID_ins_type;
    ld_num   = bus.ID_ins_number;
`ifdef EX_MUL_EN
    mul_start = vld_p0 & (bus.id_aluc == OP_MUL);
    load      = adv & (state != S_MUL);
    ld_vld    = vld_p0 & ~mul_start;
    if (state == S_DONE) begin
      ld_vld   = 1'b1;
      ld_alu   = prod;
      ld_inb   = sh_inb;
      ld_pc    = sh_pc;
      ld_dest  = sh_dest;
      ld_wreg  = sh_wreg;
      ld_m2reg = sh_m2reg;
      ld_wmem  = sh_wmem;
      ld_br_en = sh_branch;
      ld_type  = sh_type;
      ld_num   = sh_num;
    end
`endif
  end

`ifdef EX_MUL_EN
  assign bus.ex_ready = (state == S_IDLE) & adv;
`else
  assign bus.ex_ready = adv;
`endif

  // ---- p1: EX/MEM latch and multiplier sequencer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid       <= 1'b0;
      bus.ex_wreg        <= 1'b0;
      bus.ex_m2reg       <= 1'b0;
      bus.ex_wmem        <= 1'b0;
      bus.ex_branch      <= 1'b0;
      bus.ex_aluR        <= '0;
      bus.ex_inB         <= '0;
      bus.ex_pc          <= '0;
      bus.ex_destR       <= '0;
      bus.EXE_ins_type   <= '0;
      bus.EXE_ins_number <= '0;
`ifdef EX_MUL_EN
      state <= S_IDLE;
      cnt   <= '0;
`endif
    end else if (bus.flush) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_wreg   <= 1'b0;
      bus.ex_wmem   <= 1'b0;
      bus.ex_branch <= 1'b0;
`ifdef EX_MUL_EN
      state <= S_IDLE;
      cnt   <= '0;
`endif
    end else begin
      if (load) begin
        bus.ex_valid       <= ld_vld;
        bus.ex_wreg        <= ld_wreg;
        bus.ex_m2reg       <= ld_m2reg;
        bus.ex_wmem        <= ld_wmem;
        bus.ex_branch      <= ld_br_en & (ld_alu == '0);
        bus.ex_aluR        <= ld_alu;
        bus.ex_inB         <= ld_inb;
        bus.ex_pc          <= ld_pc;
        bus.ex_destR       <= ld_dest;
        bus.EXE_ins_type   <= ld_type;
        bus.EXE_ins_number <= ld_num;
      end
`ifdef EX_MUL_EN
      case (state)
        S_IDLE: begin
          if (adv && mul_start) begin
            mcand     <= op_a_p0;
            mplier    <= op_b_p0;
            prod      <= '0;
            sh_inb    <= fb_p0;
            sh_pc     <= tgt_p0;
            sh_dest   <= dest_p0;
            sh_wreg   <= bus.id_wreg;
            sh_m2reg  <= bus.id_m2reg;
            sh_wmem   <= bus.id_wmem;
            sh_branch <= bus.id_branch;
            sh_type   <= bus.ID_ins_type;
            sh_num    <= bus.ID_ins_number;
            cnt       <= '0;
            state     <= S_MUL;
          end
        end
        S_MUL: begin
          // Only the low XLEN product bits are kept, so modulo accumulation suffices.
          prod   <= prod + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= S_DONE;
        end
        S_DONE: begin
          if (adv) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`endif
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed-vector bench for ex_stage_pipe; expected values are hand-computed constants.
module tb_ex_stage_pipe;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_stage_pipe_if #(.XLEN(XLEN), .RA_W(RA_W), .TAG_W(TAG_W)) bus ();

  ex_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.id_valid      = 1'b0;
    bus.flush         = 1'b0;
    bus.mem_ready     = 1'b1;
    bus.id_inA        = '0;
    bus.id_inB        = '0;
    bus.id_imm        = '0;
    bus.id_pc4        = '0;
    bus.fwd_a_sel     = 2'b00;
    bus.fwd_b_sel     = 2'b00;
    bus.mem_fwd       = '0;
    bus.wb_fwd        = '0;
    bus.id_aluc       = 4'h0;
    bus.id_aluimm     = 1'b0;
    bus.id_shift      = 1'b0;
    bus.id_regrt      = 1'b0;
    bus.id_wreg       = 1'b0;
    bus.id_m2reg      = 1'b0;
    bus.id_wmem       = 1'b0;
    bus.id_branch     = 1'b0;
    bus.id_rt         = '0;
    bus.id_rd         = '0;
    bus.ID_ins_type   = '0;
    bus.ID_ins_number = '0;
  endtask

  task automatic op(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b);
    bus.id_valid = 1'b1;
    bus.id_aluc  = aluc;
    bus.id_inA   = a;
    bus.id_inB   = b;
    step();
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] aluc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    op(aluc, a, b);
    chk_eq(tag, bus.ex_aluR, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bad;
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_eq("rst_valid", bus.ex_valid, 0);
    chk_eq("rst_aluR", bus.ex_aluR, 0);
    chk_eq("rst_pc", bus.ex_pc, 0);
    chk_eq("rst_wreg", bus.ex_wreg, 0);
    chk_eq("rst_destR", bus.ex_destR, 0);
    chk_eq("rst_ready", bus.ex_ready, 1);

    // Basic ALU operations
    bus.id_wreg = 1'b1;
    bus.id_rd   = 5'd3;
    alu_vec("add", 4'h0, 32'd5, 32'd7, 32'd12);
    chk_eq("add_valid", bus.ex_valid, 1);
    chk_eq("add_destR", bus.ex_destR, 3);
    chk_eq("add_wreg", bus.ex_wreg, 1);
    alu_vec("sub_neg", 4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_vec("sub_wrap", 4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_vec("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    alu_vec("and", 4'h2, 32'hF0F0, 32'hFF00, 32'hF000);
    alu_vec("or", 4'h3, 32'hF0F0, 32'hFF00, 32'hFFF0);
    alu_vec("xor", 4'h4, 32'hF0F0, 32'hFF00, 32'h0FF0);
    alu_vec("nor", 4'h5, 32'hF0F0, 32'hFF00, 32'hFFFF_000F);
    alu_vec("slt_t", 4'h6, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("slt_f", 4'h6, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu_vec("sll", 4'h7, 32'd4, 32'd1, 32'h10);
    alu_vec("sll_mask", 4'h7, 32'd33, 32'd1, 32'd2);
    alu_vec("srl", 4'h8, 32'd4, 32'h8000_0000, 32'h0800_0000);
    alu_vec("sra_neg", 4'h9, 32'd4, 32'h8000_0000, 32'hF800_0000);
    alu_vec("sra_pos", 4'h9, 32'd4, 32'h4000_0000, 32'h0400_0000);
    alu_vec("op_a", 4'hA, 32'd5, 32'd7, 32'd0);
    alu_vec("op_e", 4'hE, 32'd5, 32'd7, 32'd0);

    // Shift amount from immediate, immediate B operand
    clr();
    bus.id_shift = 1'b1;
    bus.id_imm   = 32'h0000_00C0;
    alu_vec("shamt_imm", 4'h7, 32'hFFFF_FFFF, 32'd1, 32'd8);
    clr();
    bus.id_aluimm = 1'b1;
    bus.id_imm    = 32'hFFFF_FFFE;
    alu_vec("aluimm", 4'h0, 32'd10, 32'd99, 32'd8);

    // Forwarding
    clr();
    bus.fwd_a_sel = 2'b01;
    bus.mem_fwd   = 32'h10;
    alu_vec("fwd_mem_a", 4'h0, 32'd0, 32'd1, 32'h11);
    clr();
    bus.fwd_b_sel = 2'b10;
    bus.wb_fwd    = 32'hABCD;
    bus.id_aluimm = 1'b1;
    bus.id_imm    = 32'd4;
    bus.id_wmem   = 1'b1;
    alu_vec("sw_addr", 4'h0, 32'h100, 32'd55, 32'h104);
    chk_eq("sw_inB", bus.ex_inB, 32'hABCD);
    chk_eq("sw_wmem", bus.ex_wmem, 1);
    clr();
    bus.fwd_a_sel = 2'b11;
    bus.mem_fwd   = 32'd100;
    alu_vec("fwd_sel11", 4'h0, 32'd2, 32'd3, 32'd5);

    // Destination select and tags
    clr();
    bus.id_regrt      = 1'b1;
    bus.id_rt         = 5'd7;
    bus.id_rd         = 5'd9;
    bus.id_m2reg      = 1'b1;
    bus.ID_ins_type   = 4'd5;
    bus.ID_ins_number = 4'hA;
    op(4'h0, 32'd1, 32'd1);
    chk_eq("regrt_dest", bus.ex_destR, 7);
    chk_eq("m2reg", bus.ex_m2reg, 1);
    chk_eq("tag_type", bus.EXE_ins_type, 5);
    chk_eq("tag_num", bus.EXE_ins_number, 4'hA);

    // Branch resolution
    clr();
    bus.id_branch = 1'b1;
    bus.id_pc4    = 32'h100;
    bus.id_imm    = 32'd3;
    op(4'h1, 32'd9, 32'd9);
    chk_eq("br_taken", bus.ex_branch, 1);
    chk_eq("br_pc", bus.ex_pc, 32'h10C);
    op(4'h1, 32'd9, 32'd8);
    chk_eq("br_not", bus.ex_branch, 0);
    chk_eq("br_not_aluR", bus.ex_aluR, 1);

    // Bubble still loads fields, marked dead
    clr();
    bus.id_inA = 32'd1;
    bus.id_inB = 32'd2;
    step();
    chk_eq("bubble_valid", bus.ex_valid, 0);
    chk_eq("bubble_aluR", bus.ex_aluR, 3);
    bus.mem_ready = 1'b0;
    #1;
    chk_eq("bubble_ready_bp", bus.ex_ready, 1);

    // MEM back-pressure
    clr();
    op(4'h0, 32'd1, 32'd1);
    bus.mem_ready = 1'b0;
    bus.id_inA    = 32'd20;
    bus.id_inB    = 32'd22;
    #1;
    chk_eq("stall_ready", bus.ex_ready, 0);
    repeat (3) step();
    chk_eq("stall_hold", bus.ex_aluR, 2);
    chk_eq("stall_valid", bus.ex_valid, 1);
    bus.mem_ready = 1'b1;
    #1;
    chk_eq("stall_release_rdy", bus.ex_ready, 1);
    step();
    chk_eq("stall_load", bus.ex_aluR, 42);

    // Flush
    clr();
    bus.id_wreg   = 1'b1;
    bus.id_wmem   = 1'b1;
    bus.id_branch = 1'b1;
    op(4'h1, 32'd4, 32'd4);
    chk_eq("pre_flush_wreg", bus.ex_wreg, 1);
    chk_eq("pre_flush_br", bus.ex_branch, 1);
    bus.flush  = 1'b1;
    bus.id_inA = 32'd50;
    step();
    bus.flush = 1'b0;
    chk_eq("flush_valid", bus.ex_valid, 0);
    chk_eq("flush_wreg", bus.ex_wreg, 0);
    chk_eq("flush_wmem", bus.ex_wmem, 0);
    chk_eq("flush_branch", bus.ex_branch, 0);

`ifdef EX_MUL_EN
    // Iterative multiply
    clr();
    bus.id_wreg  = 1'b1;
    bus.id_rd    = 5'd4;
    bus.id_valid = 1'b1;
    bus.id_aluc  = 4'hF;
    bus.id_inA   = 32'hFFFF;
    bus.id_inB   = 32'h1_0001;
    #1;
    chk_eq("mul_rdy_idle", bus.ex_ready, 1);
    step();
    chk_eq("mul_accept_vld", bus.ex_valid, 0);
    bus.id_aluc = 4'h0;
    bus.id_inA  = 32'd0;
    bus.id_inB  = 32'd0;
    bus.id_rd   = 5'd1;
    lat = 0;
    bad = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.ex_valid === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.ex_ready !== 1'b0) bad++;
    end
    chk_eq("mul_latency", lat, 33);
    chk_eq("mul_ready_low", bad, 0);
    chk_eq("mul_result", bus.ex_aluR, 32'hFFFF_FFFF);
    chk_eq("mul_destR", bus.ex_destR, 4);
    chk_eq("mul_wreg", bus.ex_wreg, 1);
    step();
    chk_eq("post_mul_add", bus.ex_aluR, 0);
    chk_eq("post_mul_dest", bus.ex_destR, 1);

    // Flush mid-multiply
    clr();
    bus.id_valid = 1'b1;
    bus.id_aluc  = 4'hF;
    bus.id_inA   = 32'd3;
    bus.id_inB   = 32'd5;
    step();
    bus.id_valid = 1'b0;
    repeat (5) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk_eq("mflush_ready", bus.ex_ready, 1);
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.ex_valid !== 1'b0) bad++;
    end
    chk_eq("mflush_no_result", bad, 0);

    // Reset mid-multiply
    bus.id_valid = 1'b1;
    bus.id_aluc  = 4'hF;
    step();
    bus.id_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("mrst_ready", bus.ex_ready, 1);
    chk_eq("mrst_aluR", bus.ex_aluR, 0);
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.ex_valid !== 1'b0) bad++;
    end
    chk_eq("mrst_no_result", bad, 0);
`else
    // Without the multiplier, aluc=F is a single-cycle op yielding 0
    clr();
    op(4'hF, 32'hFFFF, 32'h1_0001);
    chk_eq("mul_off_result", bus.ex_aluR, 0);
    chk_eq("mul_off_valid", bus.ex_valid, 1);
    chk_eq("mul_off_ready", bus.ex_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
